program_sequencer: RTL and testbench

Program sequencer for the 4-bit microprocessor, directly upstream of the computational unit. It generates the program-memory address each cycle. It supports sequential fetch, unconditional jumps, and jumps taken on a nonzero ALU result (from `r_eq_0`). It also handles subroutine call/return through a small internal return-address stack. The instruction decoder drives its control strobes, and the ALU-result-zero flag comes back from the computational unit.

---
 rtl/program_sequencer_if.sv | 26 ++
 rtl/program_sequencer.sv | 102 ++++++++++
 tb/tb_program_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Control strobes from the instruction decoder and address/status returned by the sequencer.
interface program_sequencer_if;
    logic       hold;
    logic       jmp;
    logic       jmp_nz;
    logic       call;
    logic       ret;
    logic       r_eq_0;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic [7:0] from_PS;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    modport master (
        output hold, jmp, jmp_nz, call, ret, r_eq_0, jmp_addr,
        input  pm_addr, pc, from_PS, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  hold, jmp, jmp_nz, call, ret, r_eq_0, jmp_addr,
        output pm_addr, pc, from_PS, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/program_sequencer.sv
// Program-memory address generator for the 4-bit CPU: sequential fetch, jumps,
// conditional jumps on a nonzero ALU result, and call/return via a small LIFO.
module program_sequencer #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic                 clk,
    input logic                 sync_reset,
    program_sequencer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
    localparam logic [PTR_W-2:0] IDX_ONE = (PTR_W-1)'(1);

    logic [7:0]       pc_r;
    logic [7:0]       pm_next;
    logic [7:0]       pc_inc;
    logic [7:0]       jump_target;
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_next;
    logic [PTR_W-2:0] push_idx;
    logic [PTR_W-2:0] top_idx;
    logic [7:0]       stack [STACK_DEPTH];
    logic             push;
    logic             pop;
    logic             err_set;
    logic             empty_r;
    logic             full_r;
    logic             err_r;

    assign pc_inc      = pc_r + 8'd1;
    assign jump_target = {bus.jmp_addr, 4'h0};
    // Low bits of sp address the entry array; at sp==DEPTH they wrap to 0, so sp-1 still hits the top entry.
    assign push_idx    = sp[PTR_W-2:0];
    assign top_idx     = sp[PTR_W-2:0] - IDX_ONE;

    always_comb begin
        pm_next = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        sp_next = sp;
        if (sync_reset) begin
            pm_next = '0;
        end else if (bus.hold) begin
            pm_next = pc_r;
        end else if (bus.ret) begin
            if (sp == '0) begin
                err_set = 1'b1;
            end else begin
                pop     = 1'b1;
                pm_next = stack[top_idx];
                sp_next = sp - SP_ONE;
            end
        end else if (bus.call) begin
            pm_next = jump_target;
            if (sp == SP_FULL) begin
                err_set = 1'b1;
            end else begin
                push    = 1'b1;
                sp_next = sp + SP_ONE;
            end
        end else if (bus.jmp) begin
            pm_next = jump_target;
        end else if (bus.jmp_nz && !bus.r_eq_0) begin
            pm_next = jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_r    <= '0;
            sp      <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            pc_r    <= pm_next;
            sp      <= sp_next;
            empty_r <= (sp_next == '0);
            full_r  <= (sp_next == SP_FULL);
            err_r   <= err_r | err_set;
        end
    end

    // Entry contents are deliberately left unreset; only sp defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= pc_inc;
        end
    end

    assign bus.pm_addr     = pm_next;
    assign bus.pc          = pc_r;
    assign bus.from_PS     = pc_r;
    assign bus.stack_empty = empty_r;
    assign bus.stack_full  = full_r;
    assign bus.stack_err   = err_r;

    logic unused_pop;
    assign unused_pop = pop;
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: driver queues expected address/flags, monitor checks.
module tb_program_sequencer;
    typedef struct {
        logic [7:0] pm;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic sync_reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t sb[$];
    logic [7:0] ep = 8'h00;

    program_sequencer_if bus();

    program_sequencer #(.STACK_DEPTH(4)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: combinational address before the edge, registered state after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb[0];
                check("pm_addr", bus.pm_addr, e.pm);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check("pc", bus.pc, e.pm);
                check("from_PS", bus.from_PS, e.pm);
                check("stack_empty", {7'd0, bus.stack_empty}, {7'd0, e.empty});
                check("stack_full", {7'd0, bus.stack_full}, {7'd0, e.full});
                check("stack_err", {7'd0, bus.stack_err}, {7'd0, e.err});
            end
        end
    end

    task automatic step(input logic rst, input logic h, input logic j, input logic jn,
                        input logic c, input logic r, input logic rz, input logic [3:0] a,
                        input logic [7:0] e_pm, input logic e_em, input logic e_fu, input logic e_er);
        exp_t e;
        @(posedge clk);
        #2;
        sync_reset   = rst;
        bus.hold     = h;
        bus.jmp      = j;
        bus.jmp_nz   = jn;
        bus.call     = c;
        bus.ret      = r;
        bus.r_eq_0   = rz;
        bus.jmp_addr = a;
        e.pm = e_pm; e.empty = e_em; e.full = e_fu; e.err = e_er;
        sb.push_back(e);
        ep = e_pm;
    endtask

    task automatic idle(input int unsigned n, input logic em, input logic fu, input logic er);
        for (int unsigned i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 4'h0, ep + 8'd1, em, fu, er);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hold = 0; bus.jmp = 0; bus.jmp_nz = 0; bus.call = 0;
        bus.ret = 0; bus.r_eq_0 = 0; bus.jmp_addr = 4'h0;

        // reset and 300-cycle sequential run with wrap
        step(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 0);
        idle(300, 1, 0, 0);

        // jumps
        step(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 0);
        idle(5, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 4'hA, 8'hA0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1, 4'h3, 8'hA1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 4'h3, 8'h30, 1, 0, 0);

        // nested call/return
        step(0, 0, 1, 0, 0, 0, 0, 4'h1, 8'h10, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h4, 8'h40, 0, 0, 0);
        idle(2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h7, 8'h70, 0, 0, 0);
        idle(1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h43, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h11, 1, 0, 0);

        // overflow then underflow
        step(0, 0, 0, 0, 1, 0, 0, 4'h1, 8'h10, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h2, 8'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h3, 8'h30, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h4, 8'h40, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h5, 8'h50, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h31, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h21, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h11, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h12, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h13, 1, 0, 1);

        // priority and hold
        step(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 4'h0, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h2, 8'h20, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 0, 4'h9, 8'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 4'h6, 8'h01, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 4'h8, 8'h80, 1, 0, 0);
        idle(1, 1, 0, 0);

        // return address wrap FF+1 -> 00
        step(0, 0, 1, 0, 0, 0, 0, 4'hF, 8'hF0, 1, 0, 0);
        idle(15, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h2, 8'h20, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h00, 1, 0, 0);

        // reset mid-operation discards the stack
        step(0, 0, 0, 0, 1, 0, 0, 4'h3, 8'h30, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'h5, 8'h50, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 4'h6, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h01, 1, 0, 1);
        idle(1, 1, 0, 1);

        @(posedge clk);
        #3;
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
